vertex_update_apply: RTL and testbench

Per-core consumer of the scheduler's update stream and its iteration-end marker. Buffers incoming `update_v_id/value` pairs and applies a min-reduction read-modify-write to a local vertex-value RAM. Forwards each vertex whose value improved to the next stage as an active vertex for the next iteration. After the iteration-end marker, it drains and emits one `iteration_done` pulse with the improvement count. Its `stage_full` drives the scheduler's `next_stage_full`.

---
 rtl/vertex_update_apply.sv | 251 +++++++++++++++++++++++++
 tb/tb_vertex_update_apply.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_update_apply.sv
// Per-core min-reduction apply stage: buffers scheduler updates, does read-modify-write on the
// local vertex-value RAM and forwards improved vertices; reports iteration completion.

`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef V_VALUE_WIDTH
`define V_VALUE_WIDTH 32
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif
`ifndef FIFO_SIZE_WIDTH
`define FIFO_SIZE_WIDTH 4
`endif

module vertex_update_apply #(
    parameter int unsigned V_ID_WIDTH       = `V_ID_WIDTH,
    parameter int unsigned V_VALUE_WIDTH    = `V_VALUE_WIDTH,
    parameter int unsigned ITERATION_WIDTH  = `ITERATION_WIDTH,
    parameter int unsigned CORE_ID          = 0,
    parameter int unsigned CORE_NUM_WIDTH   = 5,
    parameter int unsigned LOCAL_ADDR_WIDTH = 10,
    parameter int unsigned FIFO_SIZE_WIDTH  = `FIFO_SIZE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [V_ID_WIDTH-1:0]      update_v_id,
    input  logic [V_VALUE_WIDTH-1:0]   update_v_value,
    input  logic                       update_v_valid,
    input  logic                       iteration_end,
    input  logic                       iteration_end_valid,
    input  logic [ITERATION_WIDTH-1:0] iteration_id,
    input  logic                       next_stage_full,
    output logic                       stage_full,
    output logic [V_ID_WIDTH-1:0]      next_active_v_id,
    output logic [V_VALUE_WIDTH-1:0]   next_active_v_value,
    output logic                       next_active_v_valid,
    output logic                       iteration_done,
    output logic [ITERATION_WIDTH-1:0] done_iteration_id,
    output logic [V_ID_WIDTH-1:0]      improved_count,
    output logic                       id_error
);

    localparam int unsigned Depth    = 2 ** FIFO_SIZE_WIDTH;
    localparam int unsigned RamDepth = 2 ** LOCAL_ADDR_WIDTH;
    localparam int unsigned EntryW   = V_ID_WIDTH + V_VALUE_WIDTH;
    localparam int unsigned CntW     = FIFO_SIZE_WIDTH + 1;

    localparam logic [CntW-1:0]           DepthCnt   = CntW'(Depth);
    localparam logic [CntW-1:0]           FullThresh = CntW'(Depth - 4);
    localparam logic [CORE_NUM_WIDTH-1:0] CoreIdBits = CORE_ID[CORE_NUM_WIDTH-1:0];

    typedef enum logic [1:0] {StInit, StRun, StDrain} state_e;

    state_e state_q, state_d;

    // Input FIFO (first-word-fall-through)
    logic [EntryW-1:0]          fifo_mem [Depth];
    logic [FIFO_SIZE_WIDTH-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]            count_q, count_d;
    logic                       fifo_empty, fifo_full, fifo_wr, fifo_rd, overflow;
    logic [EntryW-1:0]          head;
    logic [V_ID_WIDTH-1:0]      pop_id;
    logic [V_VALUE_WIDTH-1:0]   pop_val;
    logic [LOCAL_ADDR_WIDTH-1:0] pop_addr;
    logic                       pop_owned;

    // Stage A -> B registers
    logic                       a_valid_q, a_valid_d;
    logic [V_ID_WIDTH-1:0]      a_id_q;
    logic [V_VALUE_WIDTH-1:0]   a_val_q;
    logic [LOCAL_ADDR_WIDTH-1:0] b_addr;

    // Value RAM and forwarding
    logic [V_VALUE_WIDTH-1:0]    ram [RamDepth];
    logic [V_VALUE_WIDTH-1:0]    ram_rdata_q;
    logic                        ram_we;
    logic [LOCAL_ADDR_WIDTH-1:0] ram_waddr;
    logic [V_VALUE_WIDTH-1:0]    ram_wdata;
    logic [LOCAL_ADDR_WIDTH-1:0] init_addr_q;
    logic                        fwd_valid_q;
    logic [LOCAL_ADDR_WIDTH-1:0] fwd_addr_q;
    logic [V_VALUE_WIDTH-1:0]    fwd_val_q;
    logic [V_VALUE_WIDTH-1:0]    old_val;
    logic                        improve;

    // Control / outputs
    logic                       end_marker;
    logic [ITERATION_WIDTH-1:0] iter_id_q, iter_id_d;
    logic                       done_q, done_d;
    logic [V_ID_WIDTH-1:0]      cnt_q, cnt_d;
    logic                       id_error_q, id_error_d;
    logic                       stage_full_q, stage_full_d;
    logic                       out_valid_q;
    logic [V_ID_WIDTH-1:0]      out_id_q;
    logic [V_VALUE_WIDTH-1:0]   out_val_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DepthCnt);
    assign fifo_wr    = update_v_valid && (state_q != StInit) && !fifo_full;
    assign overflow   = update_v_valid && (state_q != StInit) && fifo_full;
    assign fifo_rd    = !fifo_empty && !next_stage_full && (state_q != StInit);

    assign head      = fifo_mem[rptr_q];
    assign pop_id    = head[EntryW-1:V_VALUE_WIDTH];
    assign pop_val   = head[V_VALUE_WIDTH-1:0];
    assign pop_addr  = pop_id[CORE_NUM_WIDTH+LOCAL_ADDR_WIDTH-1:CORE_NUM_WIDTH];
    assign pop_owned = (pop_id[CORE_NUM_WIDTH-1:0] == CoreIdBits);
    assign a_valid_d = fifo_rd && pop_owned;

    assign b_addr  = a_id_q[CORE_NUM_WIDTH+LOCAL_ADDR_WIDTH-1:CORE_NUM_WIDTH];
    // The RAM returns pre-write data, so last cycle's write must be bypassed.
    assign old_val = (fwd_valid_q && (fwd_addr_q == b_addr)) ? fwd_val_q : ram_rdata_q;
    assign improve = a_valid_q && (a_val_q < old_val);

    assign ram_we    = (state_q == StInit) || improve;
    assign ram_waddr = (state_q == StInit) ? init_addr_q : b_addr;
    assign ram_wdata = (state_q == StInit) ? '1 : a_val_q;

    assign end_marker = iteration_end && iteration_end_valid;

    always_comb begin
        count_d = count_q;
        if (fifo_wr && !fifo_rd) begin
            count_d = count_q + 1'b1;
        end else if (!fifo_wr && fifo_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        iter_id_d = iter_id_q;
        done_d    = 1'b0;
        unique case (state_q)
            StInit: begin
                if (init_addr_q == '1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (end_marker) begin
                    state_d   = StDrain;
                    iter_id_d = iteration_id;
                end
            end
            StDrain: begin
                if (end_marker) begin
                    iter_id_d = iteration_id;
                end
                if (fifo_empty && !a_valid_q) begin
                    done_d  = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        // Clear after the done pulse, keeping an improvement landing in that same cycle.
        if (done_q) begin
            cnt_d = {{(V_ID_WIDTH-1){1'b0}}, improve};
        end else if (improve && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        id_error_d   = id_error_q || overflow || (fifo_rd && !pop_owned);
        stage_full_d = (state_d == StInit) || (count_d >= FullThresh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInit;
            init_addr_q  <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            a_valid_q    <= 1'b0;
            a_id_q       <= '0;
            a_val_q      <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_addr_q   <= '0;
            fwd_val_q    <= '0;
            iter_id_q    <= '0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            id_error_q   <= 1'b0;
            stage_full_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_val_q    <= '0;
        end else begin
            state_q      <= state_d;
            if (state_q == StInit) begin
                init_addr_q <= init_addr_q + 1'b1;
            end
            if (fifo_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (fifo_rd) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q      <= count_d;
            a_valid_q    <= a_valid_d;
            if (fifo_rd) begin
                a_id_q  <= pop_id;
                a_val_q <= pop_val;
            end
            fwd_valid_q  <= improve;
            if (improve) begin
                fwd_addr_q <= b_addr;
                fwd_val_q  <= a_val_q;
                out_id_q   <= a_id_q;
                out_val_q  <= a_val_q;
            end
            out_valid_q  <= improve;
            iter_id_q    <= iter_id_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            id_error_q   <= id_error_d;
            stage_full_q <= stage_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wptr_q] <= {update_v_id, update_v_value};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        if (a_valid_d) begin
            ram_rdata_q <= ram[pop_addr];
        end
    end

    assign stage_full          = stage_full_q;
    assign next_active_v_id    = out_id_q;
    assign next_active_v_value = out_val_q;
    assign next_active_v_valid = out_valid_q;
    assign iteration_done      = done_q;
    assign done_iteration_id   = iter_id_q;
    assign improved_count      = cnt_q;
    assign id_error            = id_error_q;

endmodule

// File: tb/tb_vertex_update_apply.sv
// Scoreboard bench for vertex_update_apply: directed updates push expected outputs into queues,
// a negedge monitor pops and compares whenever the DUT emits an output or a done pulse.

module tb_vertex_update_apply;

    localparam int unsigned IdW  = 16;
    localparam int unsigned ValW = 16;
    localparam int unsigned ItW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IdW-1:0]  update_v_id = '0;
    logic [ValW-1:0] update_v_value = '0;
    logic            update_v_valid = 1'b0;
    logic            iteration_end = 1'b0;
    logic            iteration_end_valid = 1'b0;
    logic [ItW-1:0]  iteration_id = '0;
    logic            next_stage_full = 1'b0;
    logic            stage_full;
    logic [IdW-1:0]  next_active_v_id;
    logic [ValW-1:0] next_active_v_value;
    logic            next_active_v_valid;
    logic            iteration_done;
    logic [ItW-1:0]  done_iteration_id;
    logic [IdW-1:0]  improved_count;
    logic            id_error;

    always #5 clk = ~clk;

    vertex_update_apply #(
        .V_ID_WIDTH      (IdW),
        .V_VALUE_WIDTH   (ValW),
        .ITERATION_WIDTH (ItW),
        .CORE_ID         (0),
        .CORE_NUM_WIDTH  (5),
        .LOCAL_ADDR_WIDTH(4),
        .FIFO_SIZE_WIDTH (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .update_v_id        (update_v_id),
        .update_v_value     (update_v_value),
        .update_v_valid     (update_v_valid),
        .iteration_end      (iteration_end),
        .iteration_end_valid(iteration_end_valid),
        .iteration_id       (iteration_id),
        .next_stage_full    (next_stage_full),
        .stage_full         (stage_full),
        .next_active_v_id   (next_active_v_id),
        .next_active_v_value(next_active_v_value),
        .next_active_v_valid(next_active_v_valid),
        .iteration_done     (iteration_done),
        .done_iteration_id  (done_iteration_id),
        .improved_count     (improved_count),
        .id_error           (id_error)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int n_out  = 0;

    logic [IdW+ValW-1:0] exp_q [$];
    logic [ItW+IdW-1:0]  done_exp_q [$];
    logic [IdW+ValW-1:0] mon_exp;
    logic [ItW+IdW-1:0]  mon_done_exp;

    always @(negedge clk) begin
        if (next_active_v_valid) begin
            n_out++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL out_unexpected: got id=%h val=%h, required no output",
                         next_active_v_id, next_active_v_value);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({next_active_v_id, next_active_v_value} !== mon_exp) begin
                    n_miss++;
                    $display("FAIL out_data: got id=%h val=%h, required id=%h val=%h",
                             next_active_v_id, next_active_v_value,
                             mon_exp[IdW+ValW-1:ValW], mon_exp[ValW-1:0]);
                end
            end
        end
        if (iteration_done) begin
            n_vec++;
            if (done_exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL done_unexpected: got iter=%0d count=%0d, required no pulse",
                         done_iteration_id, improved_count);
            end else begin
                mon_done_exp = done_exp_q.pop_front();
                if ({done_iteration_id, improved_count} !== mon_done_exp) begin
                    n_miss++;
                    $display("FAIL done_data: got iter=%0d count=%0d, required iter=%0d count=%0d",
                             done_iteration_id, improved_count,
                             mon_done_exp[ItW+IdW-1:IdW], mon_done_exp[IdW-1:0]);
                end
            end
            n_vec++;
            if (exp_q.size() != 0 || next_active_v_valid) begin
                n_miss++;
                $display("FAIL done_early: got %0d outputs pending, valid=%0b, required 0 and 0",
                         exp_q.size(), next_active_v_valid);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic send(input logic [IdW-1:0] id, input logic [ValW-1:0] val, input bit improves);
        update_v_id    = id;
        update_v_value = val;
        update_v_valid = 1'b1;
        if (improves) exp_q.push_back({id, val});
        @(negedge clk);
        update_v_valid = 1'b0;
    endtask

    task automatic marker(input logic [ItW-1:0] id);
        iteration_end       = 1'b1;
        iteration_end_valid = 1'b1;
        iteration_id        = id;
        @(negedge clk);
        iteration_end       = 1'b0;
        iteration_end_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int c = 0;
        while (exp_q.size() != 0 && c < max) begin
            @(negedge clk);
            c++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        int c = 0;
        rst                 = 1'b1;
        update_v_valid      = 1'b0;
        iteration_end       = 1'b0;
        iteration_end_valid = 1'b0;
        next_stage_full     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stage_full", 32'(stage_full), 1);
        check("rst_out_valid", 32'(next_active_v_valid), 0);
        check("rst_done", 32'(iteration_done), 0);
        check("rst_count", 32'(improved_count), 0);
        check("rst_id_error", 32'(id_error), 0);
        rst = 1'b0;
        while (stage_full && c < 100) begin
            c++;
            @(negedge clk);
        end
        check("init_cycles", c, 16);
    endtask

    initial begin
        int lat;
        int i;
        int full_at;
        int hold;
        int guard;
        int out0;
        int c;

        @(negedge clk);
        check("rst_done_id", 32'(done_iteration_id), 0);

        // INIT length and minimum latency
        do_reset();
        update_v_id    = 16'h0020;
        update_v_value = 16'd5;
        update_v_valid = 1'b1;
        exp_q.push_back({16'h0020, 16'd5});
        @(negedge clk);
        update_v_valid = 1'b0;
        lat = 1;
        while (!next_active_v_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        wait_drain("drain_latency", 20);

        // Back-to-back same address: forwarding
        do_reset();
        send(16'h0020, 16'd9, 1'b1);
        send(16'h0020, 16'd4, 1'b1);
        send(16'h0020, 16'd6, 1'b0);
        wait_drain("drain_fwd", 20);
        send(16'h0020, 16'd5, 1'b0);
        send(16'h0020, 16'd4, 1'b0);
        send(16'h0020, 16'd3, 1'b1);
        wait_drain("drain_ram4", 20);
        repeat (3) @(negedge clk);
        check("count_run", 32'(improved_count), 3);

        // Foreign id dropped, next update still processed
        send(16'h0021, 16'd1, 1'b0);
        repeat (4) @(negedge clk);
        check("id_error_set", 32'(id_error), 1);
        send(16'h0060, 16'd7, 1'b1);
        wait_drain("drain_foreign", 20);
        check("id_error_sticky", 32'(id_error), 1);

        // Iteration end after three improving updates
        do_reset();
        send(16'h0020, 16'd10, 1'b1);
        send(16'h0040, 16'd11, 1'b1);
        send(16'h0060, 16'd12, 1'b1);
        done_exp_q.push_back({8'd7, 16'd3});
        marker(8'd7);
        c = 0;
        while (!iteration_done && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", 32'(iteration_done), 1);
        @(negedge clk);
        check("count_cleared", 32'(improved_count), 0);
        check("done_single", 32'(iteration_done), 0);

        // Backpressure: stream 40 honouring stage_full
        do_reset();
        next_stage_full = 1'b1;
        i = 0;
        full_at = -1;
        hold = 0;
        guard = 0;
        out0 = n_out;
        while (i < 40 && guard < 2000) begin
            guard++;
            if (stage_full) begin
                update_v_valid = 1'b0;
                if (full_at < 0) begin
                    full_at = i;
                    check("out_while_held", n_out - out0, 0);
                end
                hold++;
                if (hold == 5) next_stage_full = 1'b0;
            end else begin
                update_v_id    = 16'((i % 16) << 5);
                update_v_value = 16'(1000 - i);
                update_v_valid = 1'b1;
                exp_q.push_back({16'((i % 16) << 5), 16'(1000 - i)});
                i++;
            end
            @(negedge clk);
        end
        update_v_valid = 1'b0;
        check("full_at_count", 32'(full_at), 12);
        check("sent_all", i, 40);
        wait_drain("drain_bp", 200);
        check("bp_outputs", n_out - out0, 40);

        // Reset while draining with 5 entries queued
        send(16'h0020, 16'd50, 1'b1);
        wait_drain("drain_pre_rst", 20);
        next_stage_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send(16'(16'h0040 + (k << 5)), 16'(k + 1), 1'b0);
        end
        marker(8'd9);
        repeat (2) @(negedge clk);
        do_reset();
        send(16'h0020, 16'hFFFE, 1'b1);
        send(16'h0040, 16'hFFFE, 1'b1);
        wait_drain("drain_post_rst", 20);
        repeat (10) @(negedge clk);
        check("no_done_pending", done_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
